hsi_tx_sched: RTL
=================

# hsi_tx_sched

Transmit scheduler for the HSI link. Arbitrates the single frame transmitter between the telemetry request (`tm_tx_rdy`) and the service-response request (`sr_tx_rdy`) produced by the TM/SR generator. Honours the pre-TM blackout window, spaces frames by a fixed inter-frame gap and retries failed SR frames. Sits between the TM/SR generator and the HSI transmitter.

## Interface
Parameters:
- `GAP_CYCLES`, default 16 — idle clocks enforced after every frame; legal range 1..255, 8-bit.
- `MAX_RETRY`, default 3 — maximum SR repeat requests per SR frame; 0..15, 4-bit.
- `TIMEOUT_CYCLES`, default 600000 — watchdog limit in `WAIT_DONE`; 24-bit. Only used with `HSI_TX_TIMEOUT_EN`.

Ports:
- `clk` in 1 — single clock. All logic is on the rising edge.
- `n_rst` in 1 — asynchronous, active-low reset.
- `tm_tx_rdy` in 1 — TM frame pending; level; held until acked.
- `tm_tx_ack` out 1 — one-cycle pulse; TM request consumed.
- `sr_tx_rdy` in 1 — SR frame pending; level; held until acked.
- `sr_tx_ack` out 1 — one-cycle pulse; SR request consumed.
- `pre_tm` in 1 — blackout window before a TM slot; no new SR may start while it is high.
- `sr_repeat_req` out 1 — one-cycle pulse; asks the generator to re-raise `sr_tx_rdy`.
- `sr_drop` out 1 — one-cycle pulse; SR abandoned because the retry limit was reached.
- `tx_start` out 1 — one-cycle pulse; starts one frame in the transmitter.
- `tx_sel` out 1 — frame type, 1 = TM, 0 = SR. Stable from `tx_start` until the frame ends.
- `tx_done` in 1 — one-cycle pulse from the transmitter; frame finished.
- `tx_err` in 1 — sampled with `tx_done`; 1 = frame failed.
- `tx_abort` out 1 — one-cycle pulse; watchdog abort to the transmitter.
- `tx_active` out 1 — high whenever the state is not `IDLE`.
- `err_cnt` out 8 — saturating count of failed or aborted frames.

## Operation
- States: `IDLE`, `START`, `WAIT_DONE`, `GAP`. The state register is encoded in 2 bits.
- `IDLE` decision, evaluated every cycle:
  - `tm_tx_rdy` = 1 → select TM.
  - Otherwise, `sr_tx_rdy` = 1 and `pre_tm` = 0 → select SR.
  - Otherwise stay in `IDLE`.
  - TM always wins a simultaneous request. TM is never blocked by `pre_tm`.
- `START`, one cycle:
  - `tx_start` = 1.
  - `tx_sel` = selection.
  - The matching ack pulses (`tm_tx_ack` or `sr_tx_ack`).
  - Next state is `WAIT_DONE`.
- `WAIT_DONE`: wait for `tx_done`, then go to `GAP` and load the gap counter with `GAP_CYCLES`. `tx_done` is ignored in any other state.
- Completion handling:
  - SR, `tx_err` = 1, retry count < `MAX_RETRY` → pulse `sr_repeat_req` and increment the retry count.
  - SR, `tx_err` = 1, retry count = `MAX_RETRY` → pulse `sr_drop` and clear the retry count.
  - SR, `tx_err` = 0 → clear the retry count.
  - TM errors are never retried; they only increment `err_cnt`.
- `err_cnt` increments on every `tx_err` = 1 at `tx_done`, and on every watchdog abort. It saturates at 255.
- `GAP`: decrement the gap counter each cycle. When it reaches 1, go to `IDLE`. The gap therefore lasts exactly `GAP_CYCLES` clocks.
- An SR that is pending while `pre_tm` = 1 is held. It is served only after `pre_tm` falls and no TM is pending.

## Timing
- Reset values: state `IDLE`; all outputs 0; `err_cnt` = 0; retry count 0; gap and watchdog counters 0.
- All outputs are registered.
- Request to `tx_start` latency:
  - Request (and, for SR, `pre_tm` = 0) sampled in `IDLE` at edge n.
  - `tx_start` and ack are high during cycle n+1 (the `START` state).
- `tx_done` at edge m:
  - `sr_repeat_req` / `sr_drop` are high in cycle m+1.
  - `GAP` occupies cycles m+1 .. m+`GAP_CYCLES`.
  - The earliest next `tx_start` is at m+`GAP_CYCLES`+2.
- `tx_done` in the same cycle as `tx_start` is ignored. `WAIT_DONE` lasts at least one cycle.
- `pre_tm` rising while an SR is already in `START`/`WAIT_DONE` does not affect that frame.
- `n_rst` low mid-frame returns immediately to reset values. There is no ack or repeat pulse, and a pending request is served again after reset.

## Configuration
- `HSI_TX_TIMEOUT_EN` defined:
  - A 24-bit watchdog counts cycles in `WAIT_DONE`.
  - When the count reaches `TIMEOUT_CYCLES`: `tx_abort` pulses for one cycle, the frame is treated as `tx_err` = 1 (SR retry/drop rules apply, `err_cnt` increments), and the state goes to `GAP`.
- `HSI_TX_TIMEOUT_EN` undefined: no watchdog logic, `tx_abort` is tied to 0, and `WAIT_DONE` waits for `tx_done` indefinitely.

## Test plan
- Priority: `tm_tx_rdy` and `sr_tx_rdy` both rise at edge 10 with `pre_tm` = 0.
  - `tx_start` with `tx_sel` = 1 and `tm_tx_ack` in cycle 11.
  - After `tx_done` and `GAP_CYCLES` = 16, the SR `tx_start` (`tx_sel` = 0) follows 18 cycles after `tx_done`.
- Blackout: `sr_tx_rdy` = 1 with `pre_tm` = 1 for 100 cycles → no `tx_start`. `pre_tm` falls at edge 200 → `sr_tx_ack` and `tx_start` in cycle 201.
- SR retry: 4 consecutive SR frames end with `tx_err` = 1 (`MAX_RETRY` = 3) → three `sr_repeat_req` pulses, then one `sr_drop`; `err_cnt` = 4.
- TM error: `tx_done` with `tx_err` = 1 on a TM frame → no `sr_repeat_req`; `err_cnt` increments by 1.
- Watchdog (macro on, `TIMEOUT_CYCLES` = 1000): no `tx_done` after SR `tx_start` → `tx_abort` 1000 cycles into `WAIT_DONE`, `sr_repeat_req` next cycle. With the macro off: `tx_active` stays 1 indefinitely.
- Reset mid-`WAIT_DONE`: `n_rst` pulsed low → all outputs 0 immediately, and the held `tm_tx_rdy` is restarted 2 cycles after `n_rst` rises.

Source files
------------

// File: rtl/hsi_tx_sched.sv
// rtl/hsi_tx_sched.sv - HSI transmit scheduler: TM/SR arbitration, inter-frame gap, SR retry
// Optional WAIT_DONE watchdog enabled by defining HSI_TX_TIMEOUT_EN.
module hsi_tx_sched #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 600000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tm_tx_rdy,
    output logic       tm_tx_ack,
    input  logic       sr_tx_rdy,
    output logic       sr_tx_ack,
    input  logic       pre_tm,
    output logic       sr_repeat_req,
    output logic       sr_drop,
    output logic       tx_start,
    output logic       tx_sel,
    input  logic       tx_done,
    input  logic       tx_err,
    output logic       tx_abort,
    output logic       tx_active,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_t     r_state, w_next_state;
    logic       r_sel, w_sel;
    logic [7:0] r_gap_cnt, w_gap_cnt;
    logic [3:0] r_retry, w_retry;
    logic [7:0] r_err_cnt, w_err_cnt;
    logic       r_tm_ack, r_sr_ack, r_tx_start, r_repeat, r_drop, r_active, r_abort;
    logic       w_tm_ack, w_sr_ack, w_tx_start, w_repeat, w_drop, w_abort;
    logic       w_complete, w_fail;

`ifdef HSI_TX_TIMEOUT_EN
    localparam logic [23:0] WDOG_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0] r_wdog;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_wdog <= '0;
        else if (r_state != WAIT_DONE)
            r_wdog <= '0;
        else if (r_wdog != WDOG_LAST)
            r_wdog <= r_wdog + 24'd1;
    end

    // The abort pulse itself acts as the failed completion on the following edge.
    assign w_abort    = (r_state == WAIT_DONE) && !r_abort && !tx_done && (r_wdog == WDOG_LAST);
    assign w_complete = tx_done || r_abort;
    assign w_fail     = tx_err || r_abort;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^(24'(TIMEOUT_CYCLES));
    assign w_abort    = 1'b0;
    assign w_complete = tx_done;
    assign w_fail     = tx_err;
`endif

    always_comb begin
        w_next_state = r_state;
        w_sel        = r_sel;
        w_gap_cnt    = r_gap_cnt;
        w_retry      = r_retry;
        w_err_cnt    = r_err_cnt;
        w_tm_ack     = 1'b0;
        w_sr_ack     = 1'b0;
        w_tx_start   = 1'b0;
        w_repeat     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (tm_tx_rdy) begin
                    w_next_state = START;
                    w_sel        = 1'b1;
                    w_tx_start   = 1'b1;
                    w_tm_ack     = 1'b1;
                end else if (sr_tx_rdy && !pre_tm) begin
                    w_next_state = START;
                    w_sel        = 1'b0;
                    w_tx_start   = 1'b1;
                    w_sr_ack     = 1'b1;
                end
            end
            START: w_next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (w_complete) begin
                    w_next_state = GAP;
                    w_gap_cnt    = GAP_LOAD;
                    if (w_fail && r_err_cnt != 8'hFF)
                        w_err_cnt = r_err_cnt + 8'd1;
                    if (!r_sel) begin
                        if (!w_fail) begin
                            w_retry = 4'd0;
                        end else if (r_retry < RETRY_MAX) begin
                            w_repeat = 1'b1;
                            w_retry  = r_retry + 4'd1;
                        end else begin
                            w_drop  = 1'b1;
                            w_retry = 4'd0;
                        end
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt <= 8'd1)
                    w_next_state = IDLE;
                else
                    w_gap_cnt = r_gap_cnt - 8'd1;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sel      <= 1'b0;
            r_gap_cnt  <= '0;
            r_retry    <= '0;
            r_err_cnt  <= '0;
            r_tm_ack   <= 1'b0;
            r_sr_ack   <= 1'b0;
            r_tx_start <= 1'b0;
            r_repeat   <= 1'b0;
            r_drop     <= 1'b0;
            r_active   <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_sel      <= w_sel;
            r_gap_cnt  <= w_gap_cnt;
            r_retry    <= w_retry;
            r_err_cnt  <= w_err_cnt;
            r_tm_ack   <= w_tm_ack;
            r_sr_ack   <= w_sr_ack;
            r_tx_start <= w_tx_start;
            r_repeat   <= w_repeat;
            r_drop     <= w_drop;
            r_active   <= (w_next_state != IDLE);
            r_abort    <= w_abort;
        end
    end

    assign tm_tx_ack     = r_tm_ack;
    assign sr_tx_ack     = r_sr_ack;
    assign tx_start      = r_tx_start;
    assign tx_sel        = r_sel;
    assign sr_repeat_req = r_repeat;
    assign sr_drop       = r_drop;
    assign tx_active     = r_active;
    assign tx_abort      = r_abort;
    assign err_cnt       = r_err_cnt;
endmodule
